// File: rtl/memory_stage_if.sv
// Pipeline-side and data-memory-side signals of the memory stage.
// The slave modport is the stage itself; the master modport is the surrounding pipeline and memory.
interface memory_stage_if #(
  parameter int ADDR_W = 12
);
  logic [15:0]       result_in;
  logic [15:0]       read_data1;
  logic [15:0]       read_data2;
  logic [31:0]       pc_plus_one;
  logic [15:0]       ldm_value;
  logic [2:0]        flag_register;
  logic              mem_read;
  logic              mem_write;
  logic              mem_push;
  logic              mem_pop;
  logic [1:0]        memory_address_select;
  logic [1:0]        memory_write_src_select;
  logic              pc_choose_memory;
  logic              reg_write;
  logic              outport_enable;
  logic [1:0]        wb_sel;
  logic [2:0]        reg_write_address;

  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic              dmem_we;
  logic [15:0]       dmem_rdata;

  logic              stall;
  logic [ADDR_W-1:0] sp_out;
  logic [15:0]       mem_data_out;
  logic [15:0]       result_out;
  logic [15:0]       ldm_value_out;
  logic [31:0]       new_pc_out;
  logic              pc_load_out;
  logic              reg_write_out;
  logic              outport_enable_out;
  logic [1:0]        wb_sel_out;
  logic [2:0]        reg_write_address_out;

  modport slave (
    input  result_in, read_data1, read_data2, pc_plus_one, ldm_value, flag_register,
           mem_read, mem_write, mem_push, mem_pop, memory_address_select,
           memory_write_src_select, pc_choose_memory, reg_write, outport_enable,
           wb_sel, reg_write_address, dmem_rdata,
    output dmem_addr, dmem_wdata, dmem_we, stall, sp_out, mem_data_out, result_out,
           ldm_value_out, new_pc_out, pc_load_out, reg_write_out, outport_enable_out,
           wb_sel_out, reg_write_address_out
  );

  modport master (
    output result_in, read_data1, read_data2, pc_plus_one, ldm_value, flag_register,
           mem_read, mem_write, mem_push, mem_pop, memory_address_select,
           memory_write_src_select, pc_choose_memory, reg_write, outport_enable,
           wb_sel, reg_write_address, dmem_rdata,
    input  dmem_addr, dmem_wdata, dmem_we, stall, sp_out, mem_data_out, result_out,
           ldm_value_out, new_pc_out, pc_load_out, reg_write_out, outport_enable_out,
           wb_sel_out, reg_write_address_out
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 16-bit pipeline: data-memory port, stack pointer, two-beat PC push/pop
// sequencing with upstream stall, and the MEM/WB buffer registers.
module memory_stage #(
  parameter int ADDR_W = 12
) (
  input  logic           clk,
  input  logic           reset,
  memory_stage_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PUSH_LO, POP_HI} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] sp_inc, sp_dec;
  logic [15:0]       lo_hold_q, lo_hold_d;

  logic [15:0]       mem_data_q, result_q, ldm_value_q;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              pc_load_q, pc_load_d;
  logic              reg_write_q, outport_enable_q;
  logic [1:0]        wb_sel_q;
  logic [2:0]        reg_write_address_q;

  logic              push_only, pop_only, pc_push, pc_pop;
  logic [15:0]       src_word;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              we;
  logic              stall;

  assign sp_inc    = sp_q + 1'b1;
  assign sp_dec    = sp_q - 1'b1;
  assign push_only = bus.mem_push & ~bus.mem_pop;
  assign pop_only  = bus.mem_pop & ~bus.mem_push;
  assign pc_push   = push_only & (bus.memory_write_src_select == 2'b10);
  assign pc_pop    = pop_only & bus.pc_choose_memory;

  // A 32-bit source always starts with its high half; PUSH_LO supplies the low half.
  always_comb begin
    src_word = bus.read_data1;
    case (bus.memory_write_src_select)
      2'b00:   src_word = bus.read_data1;
      2'b01:   src_word = bus.read_data2;
      2'b10:   src_word = bus.pc_plus_one[31:16];
      default: src_word = {13'b0, bus.flag_register};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    lo_hold_d = lo_hold_q;
    new_pc_d  = new_pc_q;
    pc_load_d = 1'b0;
    addr      = bus.result_in[ADDR_W-1:0];
    wdata     = src_word;
    we        = 1'b0;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        case (bus.memory_address_select)
          2'b00:   addr = bus.result_in[ADDR_W-1:0];
          2'b01:   addr = sp_q;
          2'b10:   addr = sp_inc;
          default: addr = '0;
        endcase
        if (push_only) begin
          addr = sp_q;
          we   = 1'b1;
          sp_d = sp_dec;
          if (pc_push) begin
            stall   = 1'b1;
            state_d = PUSH_LO;
          end
        end else if (pop_only) begin
          addr = sp_inc;
          sp_d = sp_inc;
          if (pc_pop) begin
            stall     = 1'b1;
            lo_hold_d = bus.dmem_rdata;
            state_d   = POP_HI;
          end
        end else if (!(bus.mem_push && bus.mem_pop)) begin
          we = bus.mem_write;
        end
      end
      PUSH_LO: begin
        addr    = sp_q;
        wdata   = bus.pc_plus_one[15:0];
        we      = 1'b1;
        sp_d    = sp_dec;
        state_d = IDLE;
      end
      POP_HI: begin
        addr      = sp_inc;
        sp_d      = sp_inc;
        new_pc_d  = {bus.dmem_rdata, lo_hold_q};
        pc_load_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sp_q      <= '1;
      lo_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      lo_hold_q <= lo_hold_d;
    end
  end

  // The first beat of a two-cycle access registers a bubble into MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_q          <= '0;
      result_q            <= '0;
      ldm_value_q         <= '0;
      new_pc_q            <= '0;
      pc_load_q           <= 1'b0;
      reg_write_q         <= 1'b0;
      outport_enable_q    <= 1'b0;
      wb_sel_q            <= '0;
      reg_write_address_q <= '0;
    end else begin
      mem_data_q          <= bus.dmem_rdata;
      result_q            <= bus.result_in;
      ldm_value_q         <= bus.ldm_value;
      new_pc_q            <= new_pc_d;
      pc_load_q           <= pc_load_d;
      reg_write_q         <= bus.reg_write & ~stall;
      outport_enable_q    <= bus.outport_enable & ~stall;
      wb_sel_q            <= bus.wb_sel;
      reg_write_address_q <= bus.reg_write_address;
    end
  end

  assign bus.dmem_addr             = addr;
  assign bus.dmem_wdata            = wdata;
  assign bus.dmem_we               = we;
  assign bus.stall                 = stall;
  assign bus.sp_out                = sp_q;
  assign bus.mem_data_out          = mem_data_q;
  assign bus.result_out            = result_q;
  assign bus.ldm_value_out         = ldm_value_q;
  assign bus.new_pc_out            = new_pc_q;
  assign bus.pc_load_out           = pc_load_q;
  assign bus.reg_write_out         = reg_write_q;
  assign bus.outport_enable_out    = outport_enable_q;
  assign bus.wb_sel_out            = wb_sel_q;
  assign bus.reg_write_address_out = reg_write_address_q;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: drives pipeline controls, models the data memory, and checks
// MEM/WB outputs against a scoreboard of expected values pushed as each instruction is issued.
module tb_memory_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  memory_stage_if #(.ADDR_W(12)) bus ();

  memory_stage #(.ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] tb_mem [0:4095];
  assign bus.dmem_rdata = tb_mem[bus.dmem_addr];
  always @(posedge clk) if (bus.dmem_we) tb_mem[bus.dmem_addr] <= bus.dmem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sp;
    logic [15:0] mdata;
    logic        rw;
    logic        pld;
    logic [31:0] npc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic set_idle();
    bus.result_in = 16'h0; bus.read_data1 = 16'h0; bus.read_data2 = 16'h0;
    bus.pc_plus_one = 32'h0; bus.ldm_value = 16'h0; bus.flag_register = 3'b0;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_push = 0; bus.mem_pop = 0;
    bus.memory_address_select = 2'b00; bus.memory_write_src_select = 2'b00;
    bus.pc_choose_memory = 0; bus.reg_write = 0; bus.outport_enable = 0;
    bus.wb_sel = 2'b00; bus.reg_write_address = 3'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    bus.mem_read = 1; bus.result_in = 16'h5555; bus.reg_write = 1; bus.ldm_value = 16'h00AA;
    tick();
    checks++;
    if (bus.result_out !== 16'h5555) begin errors++; $display("FAIL pre_reset_result got=%h exp=5555", bus.result_out); end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.sp_out !== 12'hFFF) begin errors++; $display("FAIL reset_sp got=%h exp=fff", bus.sp_out); end
    checks++;
    if (bus.result_out !== 16'h0 || bus.reg_write_out !== 1'b0 || bus.ldm_value_out !== 16'h0 ||
        bus.pc_load_out !== 1'b0 || bus.new_pc_out !== 32'h0 || bus.mem_data_out !== 16'h0)
    begin errors++; $display("FAIL reset_outputs got result=%h rw=%b ldm=%h pld=%b npc=%h md=%h exp=all zero",
        bus.result_out, bus.reg_write_out, bus.ldm_value_out, bus.pc_load_out, bus.new_pc_out, bus.mem_data_out); end
    set_idle();
    #2 reset = 1'b1;
    tick();
    $display("test_reset done: sp=%h", bus.sp_out);
  endtask

  task automatic test_word_push_pop();
    set_idle();
    bus.mem_push = 1; bus.memory_address_select = 2'b01; bus.read_data1 = 16'hBEEF;
    #1;
    checks++;
    if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 12'hFFF || bus.dmem_wdata !== 16'hBEEF || bus.stall !== 1'b0)
    begin errors++; $display("FAIL push_port got we=%b addr=%h wd=%h stall=%b exp we=1 addr=fff wd=beef stall=0",
        bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, bus.stall); end
    sb.push_back('{sp: 12'hFFE, mdata: 16'h0, rw: 0, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp) begin errors++; $display("FAIL push_sp got=%h exp=%h", bus.sp_out, e.sp); end
    checks++;
    if (tb_mem[12'hFFF] !== 16'hBEEF) begin errors++; $display("FAIL push_mem got=%h exp=beef", tb_mem[12'hFFF]); end
    $display("push word: sp=%h mem[fff]=%h", bus.sp_out, tb_mem[12'hFFF]);

    set_idle();
    bus.mem_pop = 1; bus.memory_address_select = 2'b10; bus.reg_write = 1; bus.reg_write_address = 3'd5;
    sb.push_back('{sp: 12'hFFF, mdata: 16'hBEEF, rw: 1, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.mem_data_out !== e.mdata || bus.reg_write_out !== e.rw || bus.reg_write_address_out !== 3'd5)
    begin errors++; $display("FAIL pop_word got sp=%h md=%h rw=%b rwa=%0d exp sp=%h md=%h rw=%b rwa=5",
        bus.sp_out, bus.mem_data_out, bus.reg_write_out, bus.reg_write_address_out, e.sp, e.mdata, e.rw); end
    $display("pop word: sp=%h data=%h", bus.sp_out, bus.mem_data_out);
  endtask

  task automatic test_call_push();
    set_idle();
    bus.mem_push = 1; bus.memory_address_select = 2'b01; bus.memory_write_src_select = 2'b10;
    bus.pc_plus_one = 32'h0001_2345; bus.reg_write = 1; bus.outport_enable = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.dmem_addr !== 12'hFFF || bus.dmem_wdata !== 16'h0001 || bus.dmem_we !== 1'b1)
    begin errors++; $display("FAIL call_beat1 got stall=%b addr=%h wd=%h we=%b exp 1/fff/0001/1",
        bus.stall, bus.dmem_addr, bus.dmem_wdata, bus.dmem_we); end
    sb.push_back('{sp: 12'hFFE, mdata: 16'h0, rw: 0, pld: 0, npc: 32'h0});
    sb.push_back('{sp: 12'hFFD, mdata: 16'h0, rw: 1, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.reg_write_out !== e.rw || bus.outport_enable_out !== 1'b0)
    begin errors++; $display("FAIL call_bubble got sp=%h rw=%b oe=%b exp sp=%h rw=%b oe=0",
        bus.sp_out, bus.reg_write_out, bus.outport_enable_out, e.sp, e.rw); end
    checks++;
    if (bus.stall !== 1'b0 || bus.dmem_addr !== 12'hFFE || bus.dmem_wdata !== 16'h2345 || bus.dmem_we !== 1'b1)
    begin errors++; $display("FAIL call_beat2 got stall=%b addr=%h wd=%h we=%b exp 0/ffe/2345/1",
        bus.stall, bus.dmem_addr, bus.dmem_wdata, bus.dmem_we); end
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.reg_write_out !== e.rw || bus.outport_enable_out !== 1'b1)
    begin errors++; $display("FAIL call_done got sp=%h rw=%b oe=%b exp sp=%h rw=%b oe=1",
        bus.sp_out, bus.reg_write_out, bus.outport_enable_out, e.sp, e.rw); end
    checks++;
    if (tb_mem[12'hFFF] !== 16'h0001 || tb_mem[12'hFFE] !== 16'h2345)
    begin errors++; $display("FAIL call_mem got hi=%h lo=%h exp 0001/2345", tb_mem[12'hFFF], tb_mem[12'hFFE]); end
    $display("call push: sp=%h mem[fff]=%h mem[ffe]=%h", bus.sp_out, tb_mem[12'hFFF], tb_mem[12'hFFE]);
  endtask

  task automatic test_ret_pop();
    set_idle();
    bus.mem_pop = 1; bus.memory_address_select = 2'b10; bus.pc_choose_memory = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.dmem_addr !== 12'hFFE || bus.dmem_we !== 1'b0)
    begin errors++; $display("FAIL ret_beat1 got stall=%b addr=%h we=%b exp 1/ffe/0", bus.stall, bus.dmem_addr, bus.dmem_we); end
    sb.push_back('{sp: 12'hFFE, mdata: 16'h2345, rw: 0, pld: 0, npc: 32'h0});
    sb.push_back('{sp: 12'hFFF, mdata: 16'h0001, rw: 0, pld: 1, npc: 32'h0001_2345});
    sb.push_back('{sp: 12'hFFF, mdata: 16'h0,    rw: 0, pld: 0, npc: 32'h0001_2345});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.pc_load_out !== e.pld || bus.stall !== 1'b0)
    begin errors++; $display("FAIL ret_bubble got sp=%h pld=%b stall=%b exp sp=%h pld=%b stall=0",
        bus.sp_out, bus.pc_load_out, bus.stall, e.sp, e.pld); end
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.pc_load_out !== e.pld || bus.new_pc_out !== e.npc)
    begin errors++; $display("FAIL ret_done got sp=%h pld=%b npc=%h exp sp=%h pld=%b npc=%h",
        bus.sp_out, bus.pc_load_out, bus.new_pc_out, e.sp, e.pld, e.npc); end
    $display("ret pop: sp=%h new_pc=%h load=%b", bus.sp_out, bus.new_pc_out, bus.pc_load_out);
    set_idle();
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.pc_load_out !== e.pld || bus.new_pc_out !== e.npc)
    begin errors++; $display("FAIL ret_strobe_len got pld=%b npc=%h exp pld=%b npc=%h",
        bus.pc_load_out, bus.new_pc_out, e.pld, e.npc); end
  endtask

  task automatic test_load_store();
    set_idle();
    bus.mem_write = 1; bus.result_in = 16'h0010; bus.memory_write_src_select = 2'b01; bus.read_data2 = 16'h1234;
    #1;
    checks++;
    if (bus.dmem_we !== 1'b1 || bus.dmem_addr !== 12'h010 || bus.dmem_wdata !== 16'h1234)
    begin errors++; $display("FAIL store_port got we=%b addr=%h wd=%h exp 1/010/1234", bus.dmem_we, bus.dmem_addr, bus.dmem_wdata); end
    sb.push_back('{sp: 12'hFFF, mdata: 16'h0, rw: 0, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp) begin errors++; $display("FAIL store_sp got=%h exp=%h", bus.sp_out, e.sp); end
    set_idle();
    bus.mem_read = 1; bus.result_in = 16'h0010; bus.reg_write = 1; bus.wb_sel = 2'b01;
    sb.push_back('{sp: 12'hFFF, mdata: 16'h1234, rw: 1, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.mem_data_out !== e.mdata || bus.sp_out !== e.sp || bus.result_out !== 16'h0010 || bus.wb_sel_out !== 2'b01)
    begin errors++; $display("FAIL load got md=%h sp=%h res=%h wbs=%b exp md=%h sp=%h res=0010 wbs=01",
        bus.mem_data_out, bus.sp_out, bus.result_out, bus.wb_sel_out, e.mdata, e.sp); end
    $display("load/store: data=%h sp=%h", bus.mem_data_out, bus.sp_out);
  endtask

  task automatic test_boundaries();
    // Word pop with SP at all-ones reads address 0 and wraps SP.
    set_idle();
    tb_mem[12'h000] = 16'h7A7A;
    bus.mem_pop = 1; bus.memory_address_select = 2'b10;
    #1;
    checks++;
    if (bus.dmem_addr !== 12'h000) begin errors++; $display("FAIL wrap_addr got=%h exp=000", bus.dmem_addr); end
    sb.push_back('{sp: 12'h000, mdata: 16'h7A7A, rw: 0, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.mem_data_out !== e.mdata)
    begin errors++; $display("FAIL wrap_pop got sp=%h md=%h exp sp=%h md=%h", bus.sp_out, bus.mem_data_out, e.sp, e.mdata); end
    $display("wrap pop: sp=%h data=%h", bus.sp_out, bus.mem_data_out);

    set_idle();
    bus.mem_push = 1; bus.memory_address_select = 2'b01; bus.memory_write_src_select = 2'b11; bus.flag_register = 3'b101;
    sb.push_back('{sp: 12'hFFF, mdata: 16'h0, rw: 0, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || tb_mem[12'h000] !== 16'h0005)
    begin errors++; $display("FAIL wrap_push got sp=%h mem0=%h exp sp=%h mem0=0005", bus.sp_out, tb_mem[12'h000], e.sp); end

    set_idle();
    bus.mem_push = 1; bus.mem_pop = 1; bus.mem_write = 1; bus.reg_write = 1; bus.result_in = 16'h0ABC;
    #1;
    checks++;
    if (bus.dmem_we !== 1'b0 || bus.stall !== 1'b0)
    begin errors++; $display("FAIL pushpop_we got we=%b stall=%b exp 0/0", bus.dmem_we, bus.stall); end
    sb.push_back('{sp: 12'hFFF, mdata: 16'h0, rw: 1, pld: 0, npc: 32'h0});
    tick();
    e = sb.pop_front();
    checks++;
    if (bus.sp_out !== e.sp || bus.reg_write_out !== e.rw || bus.result_out !== 16'h0ABC)
    begin errors++; $display("FAIL pushpop_noop got sp=%h rw=%b res=%h exp sp=%h rw=%b res=0abc",
        bus.sp_out, bus.reg_write_out, bus.result_out, e.sp, e.rw); end

    // Reset while the low half of a PC push is pending.
    set_idle();
    bus.mem_push = 1; bus.memory_write_src_select = 2'b10; bus.pc_plus_one = 32'hAAAA_5555;
    tick();
    checks++;
    if (bus.sp_out !== 12'hFFE) begin errors++; $display("FAIL mid_push_sp got=%h exp=ffe", bus.sp_out); end
    #3 reset = 1'b0;
    set_idle();
    #1;
    checks++;
    if (bus.sp_out !== 12'hFFF || bus.dmem_we !== 1'b0 || tb_mem[12'hFFF] !== 16'hAAAA)
    begin errors++; $display("FAIL reset_mid_push got sp=%h we=%b mem[fff]=%h exp fff/0/aaaa",
        bus.sp_out, bus.dmem_we, tb_mem[12'hFFF]); end
    #2 reset = 1'b1;
    tick();
    checks++;
    if (bus.sp_out !== 12'hFFF || tb_mem[12'hFFE] !== 16'h2345)
    begin errors++; $display("FAIL post_reset_idle got sp=%h mem[ffe]=%h exp fff/2345", bus.sp_out, tb_mem[12'hFFE]); end
    $display("reset mid push: sp=%h", bus.sp_out);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) tb_mem[i] = 16'h0;
    reset = 1'b0;
    set_idle();
    #12 reset = 1'b1;
    tick();
    test_reset();
    test_word_push_pop();
    test_call_push();
    test_ret_pop();
    test_load_store();
    test_boundaries();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth stage of the 16-bit RISC pipeline: consumes the EX/MEM buffer (ALU result, operands, PC values, control bits) and drives the data-memory port. It owns the stack pointer and sequences 32-bit PC push/pop as two 16-bit stack accesses, asserting a stall to freeze upstream stages. It registers everything write-back needs into the MEM/WB buffer.

## Interface
- ADDR_W, 12, data-memory word-address width; stack pointer width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- result_in  in  16  ALU result / effective address.
- read_data1, read_data2  in  16 each  Rdest / Rsrc operand values.
- pc_plus_one  in  32  return address for call/interrupt pushes.
- ldm_value  in  16  immediate for LDM, passed through.
- flag_register  in  3  {carry, negative, zero}.
- mem_read, mem_write, mem_push, mem_pop  in  1 each  access type.
- memory_address_select  in  2  00 result_in, 01 SP (push), 10 SP+1 (pop), 11 zero.
- memory_write_src_select  in  2  00 read_data1, 01 read_data2, 10 pc_plus_one (32-bit), 11 {13'b0, flag_register}.
- pc_choose_memory  in  1  pop is a 32-bit PC pop (RET/RTI).
- reg_write, outport_enable  in  1 each; wb_sel  in  2; reg_write_address  in  3  write-back controls.
- dmem_addr  out  ADDR_W  data-memory address (combinational).
- dmem_wdata  out  16; dmem_we  out  1  write on clk edge when high.
- dmem_rdata  in  16  asynchronous read data for dmem_addr.
- stall  out  1  combinational; first cycle of a two-cycle access.
- sp_out  out  ADDR_W  current stack pointer.
- mem_data_out, result_out, ldm_value_out  out  16 each  MEM/WB data.
- new_pc_out  out  32; pc_load_out  out  1  popped PC and its load strobe.
- reg_write_out, outport_enable_out  out  1 each; wb_sel_out  out  2; reg_write_address_out  out  3.

## Operation
- FSM states: IDLE, PUSH_LO, POP_HI.
- IDLE, mem_push with write_src 10: write pc_plus_one[31:16] at SP, SP-=1, stall=1, go PUSH_LO. PUSH_LO: write pc_plus_one[15:0] at SP, SP-=1, go IDLE. Net SP-=2; high half at higher address.
- IDLE, mem_pop with pc_choose_memory: SP+=1, read mem[SP+1] into lo_hold, stall=1, go POP_HI. POP_HI: SP+=1, read mem[SP+1] as high half; new_pc_out={hi, lo_hold}, pc_load_out=1, go IDLE.
- Single-word push: write selected source at SP, SP-=1. Single-word pop: read mem[SP+1], SP+=1.
- mem_write / mem_read (no push/pop): address per memory_address_select; SP unchanged.
- mem_push and mem_pop both high: no-op — no write, SP unchanged, pass-through controls still registered.
- dmem_we = mem_write | mem_push (gated to the legal cases above); dmem_rdata is captured into mem_data_out.
- SP arithmetic modulo 2^ADDR_W; wrap at 0 and at all-ones is silent.
- Upstream holds all inputs stable while stall=1.

## Timing
- Single-cycle accesses: MEM/WB outputs valid one clock after inputs present.
- Two-cycle accesses: first-cycle edge registers a bubble (reg_write_out, outport_enable_out, pc_load_out = 0); second-cycle edge registers the real instruction. Latency 2 clocks.
- stall depends only on IDLE state and current inputs; never high in PUSH_LO/POP_HI.
- SP update, dmem write and MEM/WB capture occur on the same rising edge.
- Reset (asynchronous, low): FSM IDLE, SP = 2^ADDR_W-1, lo_hold = 0, all MEM/WB outputs 0; reset mid two-cycle op abandons it (half-written stack word remains).

## Test plan
- Reset: assert reset=0 mid-cycle -> sp_out=0xFFF, all registered outputs 0 immediately.
- Word push/pop: push read_data1=0xBEEF (sel 01/00) then pop -> mem[0xFFF]=0xBEEF, sp 0xFFE then 0xFFF, mem_data_out=0xBEEF.
- CALL push: pc_plus_one=0x0001_2345, sel 01/10 -> stall high 1 cycle, mem[0xFFF]=0x0001, mem[0xFFE]=0x2345, sp=0xFFD, one bubble.
- RET pop after the above -> stall 1 cycle, new_pc_out=0x0001_2345, pc_load_out=1 for one cycle, sp=0xFFF.
- Load/store: mem_write result_in=0x0010, read_data2=0x1234, then mem_read -> mem_data_out=0x1234, sp unchanged.
- Boundaries: pop at sp=0xFFF -> sp wraps to 0x000; push+pop together -> dmem_we=0, sp unchanged; reset during PUSH_LO -> IDLE, sp=0xFFF.
